// File: rtl/bram_arb_pkg.sv
// Shared types for the block-RAM arbiter: read-response owner tag and full-word strobe.
package bram_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_X, OWN_I} owner_e;

  localparam logic [3:0] FULL_STRB = 4'b1111;

endpackage

// File: rtl/bram_arbiter_if.sv
// Request/response bundle for the three RAM requesters plus the RAM-side port.
interface bram_arbiter_if #(
  parameter int unsigned AW = 14
);

  logic          d_valid;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_ready;
  logic          d_rsp_valid;

  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic          i_rsp_valid;

  logic          x_valid;
  logic          x_wr;
  logic [AW-1:0] x_addr;
  logic [31:0]   x_wdata;
  logic          x_ready;
  logic          x_rsp_valid;

  logic [31:0]   rsp_rdata;

  logic [AW-1:0] m_addr;
  logic [3:0]    m_we;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  d_valid, d_wr, d_addr, d_wdata, d_wstrb,
    input  i_valid, i_addr,
    input  x_valid, x_wr, x_addr, x_wdata,
    input  m_rdata,
    output d_ready, d_rsp_valid, i_ready, i_rsp_valid, x_ready, x_rsp_valid,
    output rsp_rdata, m_addr, m_we, m_wdata
  );

  modport master (
    output d_valid, d_wr, d_addr, d_wdata, d_wstrb,
    output i_valid, i_addr,
    output x_valid, x_wr, x_addr, x_wdata,
    output m_rdata,
    input  d_ready, d_rsp_valid, i_ready, i_rsp_valid, x_ready, x_rsp_valid,
    input  rsp_rdata, m_addr, m_we, m_wdata
  );

endinterface

// File: rtl/arb_age_counter.sv
// Saturating wait counter for one requester; flags when it has waited MaxWait cycles.
module arb_age_counter #(
  parameter int unsigned MaxWait = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic valid_i,
  input  logic ready_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!valid_i || ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(MaxWait)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == CntW'(MaxWait));

endmodule

// File: rtl/bram_arbiter.sv
// Single-port BRAM arbiter for data bus, instruction bus and DMA; fixed priority d > x > i.
// Define ARB_STARVE_GUARD_EN to let x/i preempt d after MAX_WAIT cycles of waiting.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned AW = 14
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned MAX_WAIT = 8
`endif
) (
  input logic            clk,
  input logic            resetn,
  bram_arbiter_if.slave  bus
);

  logic          d_gnt, x_gnt, i_gnt;
  logic          x_force, i_force;
  logic [AW-1:0] addr_sel;
  logic [3:0]    we_sel;
  logic [31:0]   wdata_sel;
  owner_e        owner_q, owner_d;

`ifdef ARB_STARVE_GUARD_EN
  logic x_at_limit, i_at_limit;

  arb_age_counter #(
    .MaxWait (MAX_WAIT)
  ) u_x_age (
    .clk        (clk),
    .resetn     (resetn),
    .valid_i    (bus.x_valid),
    .ready_i    (x_gnt),
    .at_limit_o (x_at_limit)
  );

  arb_age_counter #(
    .MaxWait (MAX_WAIT)
  ) u_i_age (
    .clk        (clk),
    .resetn     (resetn),
    .valid_i    (bus.i_valid),
    .ready_i    (i_gnt),
    .at_limit_o (i_at_limit)
  );

  assign x_force = bus.x_valid & x_at_limit;
  assign i_force = bus.i_valid & i_at_limit;
`else
  assign x_force = 1'b0;
  assign i_force = 1'b0;
`endif

  // Starved ports jump the queue ahead of d; x beats i when both are starved.
  always_comb begin
    d_gnt = 1'b0;
    x_gnt = 1'b0;
    i_gnt = 1'b0;
    if (resetn) begin
      if (x_force)          x_gnt = 1'b1;
      else if (i_force)     i_gnt = 1'b1;
      else if (bus.d_valid) d_gnt = 1'b1;
      else if (bus.x_valid) x_gnt = 1'b1;
      else if (bus.i_valid) i_gnt = 1'b1;
    end
  end

  always_comb begin
    addr_sel  = bus.i_addr;
    we_sel    = '0;
    wdata_sel = bus.d_wdata;
    owner_d   = OWN_NONE;
    if (d_gnt) begin
      addr_sel = bus.d_addr;
      if (bus.d_wr) we_sel  = bus.d_wstrb;
      else          owner_d = OWN_D;
    end else if (x_gnt) begin
      addr_sel  = bus.x_addr;
      wdata_sel = bus.x_wdata;
      if (bus.x_wr) we_sel  = FULL_STRB;
      else          owner_d = OWN_X;
    end else if (i_gnt) begin
      owner_d = OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.d_ready = d_gnt;
  assign bus.x_ready = x_gnt;
  assign bus.i_ready = i_gnt;

  // Gated by resetn so a response in flight when reset asserts never surfaces.
  assign bus.d_rsp_valid = resetn && (owner_q == OWN_D);
  assign bus.x_rsp_valid = resetn && (owner_q == OWN_X);
  assign bus.i_rsp_valid = resetn && (owner_q == OWN_I);
  assign bus.rsp_rdata   = bus.m_rdata;

  assign bus.m_addr  = addr_sel;
  assign bus.m_we    = we_sel;
  assign bus.m_wdata = wdata_sel;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus random traffic vs. a queue model.
module tb_bram_arbiter;

  localparam int unsigned AW      = 14;
  localparam int          MaxWait = 8;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } req_t;

  logic clk;
  logic resetn;
  logic tb_load;

  bram_arbiter_if #(.AW(AW)) bus ();

  bram_arbiter #(.AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [31:0] init_val [64];
  logic [31:0] ram      [64];
  logic [31:0] shadow   [64];

  // RAM model: registered read, byte-enable write.
  always @(posedge clk) begin
    if (tb_load) begin
      for (int k = 0; k < 64; k++) ram[k] <= init_val[k];
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.m_we[b]) ram[bus.m_addr[5:0]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      bus.m_rdata <= ram[bus.m_addr[5:0]];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  req_t        dq[$], xq[$], iq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  int          xw = 0, iw = 0;
  int          d_gnt_cyc = -1, x_gnt_cyc = -1, i_gnt_cyc = -1;
  logic [31:0] last_d_rdata = '0;
  int          x_rsp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference priority: starved x, starved i, then d > x > i.
  function automatic int pick(input bit dv, input bit xv, input bit iv, input bit rst_n);
    if (!rst_n) return 0;
`ifdef ARB_STARVE_GUARD_EN
    if (xv && xw >= MaxWait) return 2;
    if (iv && iw >= MaxWait) return 3;
`endif
    if (dv) return 1;
    if (xv) return 2;
    if (iv) return 3;
    return 0;
  endfunction

  task automatic write_shadow(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) shadow[a[5:0]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic drive();
    bus.d_valid = (dq.size() != 0);
    bus.d_wr    = dq.size() != 0 ? dq[0].wr    : 1'b0;
    bus.d_addr  = dq.size() != 0 ? dq[0].addr  : '0;
    bus.d_wdata = dq.size() != 0 ? dq[0].wdata : '0;
    bus.d_wstrb = dq.size() != 0 ? dq[0].wstrb : '0;
    bus.x_valid = (xq.size() != 0);
    bus.x_wr    = xq.size() != 0 ? xq[0].wr    : 1'b0;
    bus.x_addr  = xq.size() != 0 ? xq[0].addr  : '0;
    bus.x_wdata = xq.size() != 0 ? xq[0].wdata : '0;
    bus.i_valid = (iq.size() != 0);
    bus.i_addr  = iq.size() != 0 ? iq[0].addr  : '0;
  endtask

  task automatic cycle();
    int            w, ep;
    bit            dv, xv, iv;
    logic [3:0]    we_exp;
    logic [AW-1:0] a_exp;
    req_t          r;
    drive();
    @(negedge clk);
    dv = dq.size() != 0;
    xv = xq.size() != 0;
    iv = iq.size() != 0;
    w  = pick(dv, xv, iv, resetn);
    ep = resetn ? pend : 0;
    chk("d_ready", 32'(bus.d_ready), 32'(w == 1));
    chk("x_ready", 32'(bus.x_ready), 32'(w == 2));
    chk("i_ready", 32'(bus.i_ready), 32'(w == 3));
    chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(ep == 1));
    chk("x_rsp_valid", 32'(bus.x_rsp_valid), 32'(ep == 2));
    chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(ep == 3));
    if (ep != 0) chk("rsp_rdata", bus.rsp_rdata, pend_data);
    if (bus.d_rsp_valid) last_d_rdata = bus.rsp_rdata;
    if (bus.x_rsp_valid) x_rsp_cnt++;
    we_exp = '0;
    a_exp  = iv ? iq[0].addr : '0;
    if (w == 1) begin
      a_exp  = dq[0].addr;
      we_exp = dq[0].wr ? dq[0].wstrb : 4'h0;
    end else if (w == 2) begin
      a_exp  = xq[0].addr;
      we_exp = xq[0].wr ? 4'hF : 4'h0;
    end
    chk("m_we", 32'(bus.m_we), 32'(we_exp));
    chk("m_addr", 32'(bus.m_addr), 32'(a_exp));
    if (w == 2 && xq[0].wr) chk("m_wdata", bus.m_wdata, xq[0].wdata);
    pend = 0;
    if (w == 1) begin
      r = dq.pop_front();
      d_gnt_cyc = cyc;
      if (r.wr) write_shadow(r.addr, r.wdata, r.wstrb);
      else begin pend = 1; pend_data = shadow[r.addr[5:0]]; end
    end else if (w == 2) begin
      r = xq.pop_front();
      x_gnt_cyc = cyc;
      if (r.wr) write_shadow(r.addr, r.wdata, 4'hF);
      else begin pend = 2; pend_data = shadow[r.addr[5:0]]; end
    end else if (w == 3) begin
      r = iq.pop_front();
      i_gnt_cyc = cyc;
      pend = 3;
      pend_data = shadow[r.addr[5:0]];
    end
    if (!resetn) begin
      xw = 0;
      iw = 0;
    end else begin
      xw = (xv && w != 2) ? ((xw + 1 > MaxWait) ? MaxWait : xw + 1) : 0;
      iw = (iv && w != 3) ? ((iw + 1 > MaxWait) ? MaxWait : iw + 1) : 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((dq.size() + xq.size() + iq.size()) != 0 && n < max) begin
      cycle();
      n++;
    end
    cycle();
    chk("drain_timeout", 32'(dq.size() + xq.size() + iq.size()), 32'd0);
  endtask

  function automatic req_t mk(input bit wr, input int a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.wr = wr; r.addr = AW'(a); r.wdata = d; r.wstrb = s;
    return r;
  endfunction

  initial begin
    int base;
    for (int k = 0; k < 64; k++) init_val[k] = $urandom;
    init_val[16] = 32'hDEADBEEF;
    init_val[32] = 32'h11223344;
    for (int k = 0; k < 64; k++) shadow[k] = init_val[k];
    resetn  = 1'b0;
    tb_load = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    tb_load = 1'b0;

    // Reset with all three requesting, then release: d, x, i granted in turn.
    dq.push_back(mk(1'b0, 16, '0, '0));
    xq.push_back(mk(1'b0, 32, '0, '0));
    iq.push_back(mk(1'b0, 33, '0, '0));
    cycle();
    cycle();
    resetn = 1'b1;
    base = cyc;
    drain(10);
    chk("rel_d_first", 32'(d_gnt_cyc - base), 32'd0);
    chk("order_x", 32'(x_gnt_cyc - base), 32'd1);
    chk("order_i", 32'(i_gnt_cyc - base), 32'd2);

    // Single d read of a known word.
    dq.push_back(mk(1'b0, 16, '0, '0));
    base = cyc;
    drain(10);
    chk("d_read_gnt", 32'(d_gnt_cyc - base), 32'd0);
    chk("d_read_data", last_d_rdata, 32'hDEADBEEF);

    // Byte-strobe write then readback.
    dq.push_back(mk(1'b1, 32, 32'h0000AB00, 4'b0010));
    dq.push_back(mk(1'b0, 32, '0, '0));
    drain(10);
    chk("strb_readback", last_d_rdata, 32'h1122AB44);

    // d write and x read of the same word in the same cycle.
    dq.push_back(mk(1'b1, 40, 32'hCAFEF00D, 4'hF));
    xq.push_back(mk(1'b0, 40, '0, '0));
    drain(10);

    // Reset while an x read response is in flight.
    xq.push_back(mk(1'b0, 16, '0, '0));
    cycle();
    x_rsp_cnt = 0;
    resetn = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    repeat (3) cycle();
    chk("x_rsp_after_reset", 32'(x_rsp_cnt), 32'd0);

    // Continuous d traffic against a waiting i fetch.
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 20; k++) dq.push_back(mk(1'b0, k, '0, '0));
    iq.push_back(mk(1'b0, 50, '0, '0));
    base = cyc;
    for (int k = 0; k < 30 && iq.size() != 0; k++) cycle();
    chk("starve_i_cycle", 32'(i_gnt_cyc - base), 32'd8);
    drain(40);
`else
    for (int k = 0; k < 110; k++) dq.push_back(mk(1'b0, k % 64, '0, '0));
    iq.push_back(mk(1'b0, 50, '0, '0));
    repeat (100) cycle();
    chk("i_starved", 32'(iq.size()), 32'd1);
    drain(40);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if (dq.size() == 0 && $urandom_range(0, 99) < 60)
        dq.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom,
                        4'($urandom_range(0, 15))));
      if (xq.size() == 0 && $urandom_range(0, 99) < 40)
        xq.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom, 4'hF));
      if (iq.size() == 0 && $urandom_range(0, 99) < 40)
        iq.push_back(mk(1'b0, $urandom_range(0, 63), '0, '0));
      cycle();
    end
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
